mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit_pkg.sv | 30 +++
 rtl/mul_div_unit_md_compute.sv | 59 +++++
 rtl/mul_div_unit.sv | 115 +++++++++++
 tb/tb_mul_div_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encodings,
// default latencies and the controller state type.
package mul_div_unit_pkg;

  // md_op encodings; any value not listed behaves as MD_NONE
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  // Default busy durations; the down counter is 4 bits so both must be 1..15
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // True for the ops that occupy the unit for a latency period
  function automatic logic is_long_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_md_compute.sv
// Purely combinational arithmetic core. Returns {hi, lo} for the requested
// multiply/divide and flags a zero divisor so the caller can skip the write.
module mul_div_unit_md_compute
  import mul_div_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic signed [63:0] a_sext;
  logic signed [63:0] b_sext;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_mag_safe;
  logic [31:0] b_safe;
  logic [31:0] quot_mag;
  logic [31:0] rem_mag;
  logic [31:0] quot_s;
  logic [31:0] rem_s;

  assign a_sext = {{32{a[31]}}, a};
  assign b_sext = {{32{b[31]}}, b};

  // Signed divide is done on magnitudes so 0x80000000 / -1 cannot overflow:
  // its magnitude quotient 0x80000000 is simply not negated (signs agree).
  assign a_mag      = a[31] ? (32'd0 - a) : a;
  assign b_mag      = b[31] ? (32'd0 - b) : b;
  // Substitute a divisor of 1 on zero so the dividers never see 0
  assign b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign b_safe     = (b == 32'd0) ? 32'd1 : b;
  assign quot_mag   = a_mag / b_mag_safe;
  assign rem_mag    = a_mag % b_mag_safe;
  // Quotient truncates toward zero; remainder takes the dividend's sign
  assign quot_s     = (a[31] ^ b[31]) ? (32'd0 - quot_mag) : quot_mag;
  assign rem_s      = a[31] ? (32'd0 - rem_mag) : rem_mag;

  // Select the result for the requested op
  always_comb begin
    result      = 64'd0;
    div_by_zero = 1'b0;
    case (op)
      MD_MULT:  result = a_sext * b_sext;
      MD_MULTU: result = {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        result      = {rem_s, quot_s};
        div_by_zero = (b == 32'd0);
      end
      MD_DIVU: begin
        result      = {a % b_safe, a / b_safe};
        div_by_zero = (b == 32'd0);
      end
      default: result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO. Long ops compute their
// result at issue and hold busy for a fixed latency before committing.
// Optional feature: define MDU_CANCEL_EN to add a `cancel` input that aborts
// an in-flight op and suppresses a same-cycle start.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
`ifdef MDU_CANCEL_EN
  ,
  input  logic        cancel
`endif
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  md_state_e   state_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] tmp_hi_q;
  logic [31:0] tmp_lo_q;
  logic        dbz_q;
  logic [63:0] calc_result;
  logic        calc_dbz;
  logic        cancel_w;

`ifdef MDU_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  mul_div_unit_md_compute u_md_compute (
    .op          (md_op),
    .a           (rs_val),
    .b           (rt_val),
    .result      (calc_result),
    .div_by_zero (calc_dbz)
  );

  // Controller: issue, latency countdown and HI/LO commit
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
      dbz_q    <= 1'b0;
    end else if (cancel_w) begin
      // Abort anything in flight; HI/LO keep their pre-op contents
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_long_op(md_op)) begin
              tmp_hi_q <= calc_result[63:32];
              tmp_lo_q <= calc_result[31:0];
              dbz_q    <= calc_dbz;
              cnt_q    <= ((md_op == MD_MULT) || (md_op == MD_MULTU)) ? MULT_CNT : DIV_CNT;
              state_q  <= BUSY;
            end else if (md_op == MD_MTHI) begin
              hi_q <= rs_val;
            end else if (md_op == MD_MTLO) begin
              lo_q <= rs_val;
            end
          end
        end
        BUSY: begin
          // start is ignored here; the hazard unit never issues into BUSY
          if (cnt_q == 4'd1) begin
            if (!dbz_q) begin
              hi_q <= tmp_hi_q;
              lo_q <= tmp_lo_q;
            end
            cnt_q   <= 4'd0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Read port for mfhi/mflo; returns stale values while busy by design
  always_comb begin
    md_out = 32'd0;
    if (md_op == MD_MFHI)      md_out = hi_q;
    else if (md_op == MD_MFLO) md_out = lo_q;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: each issued op pushes its expected
// HI/LO and busy duration; they are popped and compared on completion.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .md_out (md_out)
`ifdef MDU_CANCEL_EN
    ,
    .cancel (cancel)
`endif
  );

  typedef struct {
    string       tag;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: advances m_hi/m_lo and returns the busy duration
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    lat = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULT: begin
        p = 64'(sa * sb);
        m_hi = p[63:32]; m_lo = p[31:0]; lat = 5;
      end
      MD_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        m_hi = p[63:32]; m_lo = p[31:0]; lat = 5;
      end
      MD_DIV: begin
        lat = 10;
        if (b != 32'd0) begin
          sq = sa / sb; sr = sa % sb;
          m_lo = 32'(sq); m_hi = 32'(sr);
        end
      end
      MD_DIVU: begin
        lat = 10;
        if (b != 32'd0) begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      MD_MTHI: m_hi = a;
      MD_MTLO: m_lo = a;
      default: lat = 0;
    endcase
  endtask

  // Issue one op, optionally pulse a stray start mid-busy, then score it
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit inject);
    exp_t e;
    int   lat;
    int   cyc;
    model_op(op, a, b, lat);
    e.tag = tag; e.exp_hi = m_hi; e.exp_lo = m_lo; e.exp_lat = lat;
    sb_q.push_back(e);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE; rs_val = $urandom; rt_val = $urandom;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      if (inject && cyc == 2) begin
        start = 1'b1; md_op = MD_MTHI; rs_val = 32'hDEADBEEF;
      end else begin
        start = 1'b0; md_op = MD_NONE;
      end
      @(negedge clk);
    end
    start = 1'b0; md_op = MD_NONE;
    e = sb_q.pop_front();
    check_eq({e.tag, ".busy_cycles"}, 32'(cyc), 32'(e.exp_lat));
    check_eq({e.tag, ".hi"}, hi, e.exp_hi);
    check_eq({e.tag, ".lo"}, lo, e.exp_lo);
    $display("txn %-12s op=%0d a=0x%08h b=0x%08h busy=%0d hi=0x%08h lo=0x%08h",
             e.tag, op, a, b, cyc, hi, lo);
  endtask

  // Start a mult and stay until the 3rd busy cycle (at its negedge)
  task automatic start_and_wait3(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = MD_MULT; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = MD_NONE; rs_val = 32'd0; rt_val = 32'd0;
`ifdef MDU_CANCEL_EN
    cancel = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    md_op = MD_MFHI;
    #1;
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.hi", hi, 32'd0);
    check_eq("rst.lo", lo, 32'd0);
    check_eq("rst.md_out", md_out, 32'd0);
    @(negedge clk);

    issue("mult", MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    md_op = MD_MFHI; #1;
    check_eq("mfhi", md_out, 32'hFFFFFFFF);
    md_op = MD_MFLO; #1;
    check_eq("mflo", md_out, 32'hFFFFFFFA);
    md_op = MD_NONE; #1;
    check_eq("none.md_out", md_out, 32'd0);
    md_op = 4'd15; #1;
    check_eq("bad_op.md_out", md_out, 32'd0);
    md_op = MD_NONE;
    @(negedge clk);

    issue("multu", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    issue("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    issue("divu", MD_DIVU, 32'hFFFFFFF9, 32'd2, 1'b0);
    issue("mthi", MD_MTHI, 32'h1234, 32'd0, 1'b0);
    issue("mtlo", MD_MTLO, 32'h5678, 32'd0, 1'b0);
    issue("div0", MD_DIV, 32'h99, 32'd0, 1'b1);
    check_eq("div0.hi_const", hi, 32'h1234);
    check_eq("div0.lo_const", lo, 32'h5678);

    // Reset on the 3rd busy cycle aborts the mult and clears HI/LO
    start_and_wait3(32'd6, 32'd7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check_eq("rst_mid.busy", 32'(busy), 32'd0);
    check_eq("rst_mid.hi", hi, 32'd0);
    check_eq("rst_mid.lo", lo, 32'd0);
    $display("txn %-12s reset on busy cycle 3 busy=%0d hi=0x%08h lo=0x%08h", "rst_mid", busy, hi, lo);
    @(negedge clk);

`ifdef MDU_CANCEL_EN
    issue("mthi2", MD_MTHI, 32'h1234, 32'd0, 1'b0);
    issue("mtlo2", MD_MTLO, 32'h5678, 32'd0, 1'b0);
    start_and_wait3(32'd6, 32'd7);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check_eq("cancel.busy", 32'(busy), 32'd0);
    check_eq("cancel.hi", hi, 32'h1234);
    check_eq("cancel.lo", lo, 32'h5678);
    $display("txn %-12s cancel on busy cycle 3 busy=%0d hi=0x%08h lo=0x%08h", "cancel", busy, hi, lo);
    // cancel alongside an mthi issue suppresses the write
    start = 1'b1; cancel = 1'b1; md_op = MD_MTHI; rs_val = 32'hBAD0BAD0;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; md_op = MD_NONE;
    check_eq("cancel_mthi.hi", hi, 32'h1234);
    $display("txn %-12s hi=0x%08h", "cancel_mthi", hi);
`endif

    issue("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check_eq("div_ovf.lo_const", lo, 32'h80000000);
    check_eq("div_ovf.hi_const", hi, 32'd0);
    issue("div_pos", MD_DIV, 32'd100, 32'hFFFFFFF9, 1'b0);

    for (int i = 0; i < 6; i++) begin
      logic [3:0] rop;
      rop = 4'(1 + (i % 4));
      issue($sformatf("rand%0d", i), rop, $urandom, $urandom_range(1, 32'h7FFF_FFFF) ^ (i[0] ? 32'h8000_0000 : 32'd0), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so a stuck run still ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
